// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter and its round-robin picker.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_ARB     = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam int WMASK_W = 4;
  localparam int DATA_W  = 32;

  // Width of a port index; at least one bit so a 2-port build still has a usable index.
  function automatic int idx_width(input int n);
    for (int w = 1; w < 32; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/sdram_arb_rr_pick.sv
// Combinational round-robin picker: first request after i_last (wrapping) wins.
// With SDRAM_ARB_FIXED_PRIO_EN defined, port 0 always wins when requesting.
module sdram_arb_rr_pick #(
  parameter int NUM_PORTS = 3,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last,
  output logic [NUM_PORTS-1:0] o_win_oh,
  output logic [IDX_W-1:0]     o_win_idx,
  output logic                 o_win_any
);

  logic w_found;

  always_comb begin
    o_win_oh  = '0;
    o_win_idx = '0;
    w_found   = 1'b0;
    // Scan last+1 .. last+NUM_PORTS so the previous winner is considered last.
    for (int i = 1; i <= NUM_PORTS; i++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (!w_found && (j == (int'(i_last) + i) % NUM_PORTS) && i_req[j]) begin
          w_found     = 1'b1;
          o_win_oh[j] = 1'b1;
          o_win_idx   = IDX_W'(j);
        end
      end
    end
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    if (i_req[0]) begin
      o_win_oh    = '0;
      o_win_oh[0] = 1'b1;
      o_win_idx   = '0;
    end
`endif
    o_win_any = |i_req;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among NUM_PORTS requesters.
// Optional macro SDRAM_ARB_FIXED_PRIO_EN gives port 0 absolute priority.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_WIDTH = 25
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]     req_din,
  input  logic [NUM_PORTS*WMASK_W-1:0]    req_wmask,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic [DATA_W-1:0]               req_dout,
  output logic                            mem_valid,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_W-1:0]               mem_din,
  output logic [WMASK_W-1:0]              mem_wmask,
  input  logic                            mem_ready,
  input  logic [DATA_W-1:0]               mem_dout
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  arb_state_t             r_state;
  logic [IDX_W-1:0]       r_grant;
  logic [IDX_W-1:0]       r_last;
  logic [NUM_PORTS-1:0]   r_req_ready;
  logic [DATA_W-1:0]      r_req_dout;
  logic                   r_mem_valid;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic [DATA_W-1:0]      r_mem_din;
  logic [WMASK_W-1:0]     r_mem_wmask;

  logic [NUM_PORTS-1:0]   w_win_oh;
  logic [IDX_W-1:0]       w_win_idx;
  logic                   w_win_any;
  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [DATA_W-1:0]      w_sel_din;
  logic [WMASK_W-1:0]     w_sel_wmask;

  sdram_arb_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .i_req     (req_valid),
    .i_last    (r_last),
    .o_win_oh  (w_win_oh),
    .o_win_idx (w_win_idx),
    .o_win_any (w_win_any)
  );

  always_comb begin
    w_sel_addr  = '0;
    w_sel_din   = '0;
    w_sel_wmask = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (w_win_oh[j]) begin
        w_sel_addr  = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_din   = req_din[j*DATA_W +: DATA_W];
        w_sel_wmask = req_wmask[j*WMASK_W +: WMASK_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_ARB;
      r_grant     <= '0;
      r_last      <= IDX_W'(NUM_PORTS - 1);
      r_req_ready <= '0;
      r_req_dout  <= '0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_mem_wmask <= '0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_win_any) begin
            r_grant     <= w_win_idx;
            r_last      <= w_win_idx;
            r_mem_addr  <= w_sel_addr;
            r_mem_din   <= w_sel_din;
            r_mem_wmask <= w_sel_wmask;
            r_mem_valid <= 1'b1;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            r_req_dout  <= mem_dout;
            r_mem_valid <= 1'b0;
            for (int j = 0; j < NUM_PORTS; j++) begin
              r_req_ready[j] <= (r_grant == IDX_W'(j));
            end
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // Guard cycle: the served port still shows its stale valid here.
          r_req_ready <= '0;
          r_state     <= ST_ARB;
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign req_dout  = r_req_dout;
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;
  assign mem_wmask = r_mem_wmask;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: controller model, requester model, expected-transaction queues.
module tb_sdram_arbiter;

  localparam int NP = 3;
  localparam int AW = 25;

  logic              clk;
  logic              reset;
  logic [NP-1:0]     req_valid;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*32-1:0]  req_din;
  logic [NP*4-1:0]   req_wmask;
  logic [NP-1:0]     req_ready;
  logic [31:0]       req_dout;
  logic              mem_valid;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_din;
  logic [3:0]        mem_wmask;
  logic              mem_ready;
  logic [31:0]       mem_dout;

  logic [AW-1:0]     p_addr  [NP];
  logic [31:0]       p_din   [NP];
  logic [3:0]        p_wmask [NP];
  int                want    [NP] = '{0, 0, 0};
  int                served  [NP] = '{0, 0, 0};

  assign req_addr  = {p_addr[2], p_addr[1], p_addr[0]};
  assign req_din   = {p_din[2], p_din[1], p_din[0]};
  assign req_wmask = {p_wmask[2], p_wmask[1], p_wmask[0]};

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic [3:0]    wmask;
    logic [31:0]   dout;
    int            lat;
  } mreq_t;

  typedef struct {
    int          port;
    logic [31:0] dout;
  } cpl_t;

  mreq_t mq[$];
  cpl_t  cq[$];

  int n_checks = 0;
  int n_errors = 0;

  sdram_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_din   (req_din),
    .req_wmask (req_wmask),
    .req_ready (req_ready),
    .req_dout  (req_dout),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_wmask (mem_wmask),
    .mem_ready (mem_ready),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
    p_addr[p]  = a;
    p_din[p]   = d;
    p_wmask[p] = m;
  endtask

  task automatic expect_txn(input int p, input logic [31:0] dout, input int lat, input bit with_cpl);
    mreq_t m;
    cpl_t  c;
    m.addr  = p_addr[p];
    m.din   = p_din[p];
    m.wmask = p_wmask[p];
    m.dout  = dout;
    m.lat   = lat;
    mq.push_back(m);
    if (with_cpl) begin
      c.port = p;
      c.dout = dout;
      cq.push_back(c);
    end
  endtask

  task automatic wait_mem_valid();
    for (int k = 0; k < 200 && mem_valid !== 1'b1; k++) @(negedge clk);
    check("mv_wait", mem_valid, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && (cq.size() != 0 || mq.size() != 0); k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drain", cq.size() + mq.size(), 0);
  endtask

  // Requester model: holds valid while it still owes requests, pops completions.
  initial begin
    logic [NP-1:0] prev_rdy;
    cpl_t c;
    req_valid = '0;
    prev_rdy  = '0;
    forever begin
      @(negedge clk);
      if (prev_rdy != 0) check("rdy_pulse", req_ready, 0);
      if (req_ready != 0) begin
        if (cq.size() == 0) begin
          check("cpl_unexp", req_ready, 0);
        end else begin
          c = cq.pop_front();
          check("cpl_port", req_ready, 64'(1 << c.port));
          check("cpl_dout", req_dout, c.dout);
        end
        for (int p = 0; p < NP; p++) if (req_ready[p]) served[p]++;
      end
      prev_rdy = req_ready;
      for (int p = 0; p < NP; p++) req_valid[p] = !reset && (served[p] < want[p]);
    end
  end

  // Controller model: checks each request, answers after its latency.
  initial begin
    int    lowrun;
    bit    seen;
    bit    abort;
    mreq_t m;
    mem_ready = 1'b0;
    mem_dout  = '0;
    lowrun    = 0;
    seen      = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        lowrun = 0;
        seen   = 1'b0;
      end else if (mem_valid !== 1'b1) begin
        lowrun++;
      end else begin
        if (seen) check("gap", 64'(lowrun >= 2), 1);
        seen = 1'b1;
        if (mq.size() == 0) begin
          check("mreq_unexp", mem_valid, 0);
          m.lat  = 2;
          m.dout = '0;
        end else begin
          m = mq.pop_front();
          check("mem_addr", mem_addr, m.addr);
          check("mem_din", mem_din, m.din);
          check("mem_wmask", mem_wmask, m.wmask);
        end
        abort = 1'b0;
        for (int k = 1; k < m.lat; k++) begin
          @(negedge clk);
          if (reset) begin
            abort = 1'b1;
            break;
          end
          check("mv_hold", mem_valid, 1);
        end
        if (abort) begin
          seen   = 1'b0;
          lowrun = 0;
        end else begin
          mem_dout  = m.dout;
          mem_ready = 1'b1;
          @(negedge clk);
          mem_ready = 1'b0;
          lowrun    = 1;
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < NP; p++) set_port(p, '0, '0, '0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("rst_mem_valid", mem_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_req_dout", req_dout, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    // All ports valid continuously: grant order 0,1,2,0,1,2.
    set_port(0, 25'h0001000, 32'hA0A0_0000, 4'b0000);
    set_port(1, 25'h0002000, 32'hB1B1_0000, 4'b1111);
    set_port(2, 25'h0003000, 32'hC2C2_0000, 4'b0000);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) expect_txn(p, 32'h5000_0000 + 32'(r * 16 + p), 3 + p + r, 1'b1);
    #1;
    for (int p = 0; p < NP; p++) want[p] += 2;
    drain();

    // Single read on port 1 with an 8-cycle controller.
    set_port(1, 25'h0000100, 32'h0, 4'b0000);
    expect_txn(1, 32'hDEADBEEF, 8, 1'b1);
    want[1] += 1;
    for (int k = 0; k < 50 && req_valid[1] !== 1'b1; k++) begin
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    check("rd_lat_valid", mem_valid, 1);
    check("rd_lat_addr", mem_addr, 25'h0000100);
    drain();
    check("rd_dout_hold", req_dout, 32'hDEADBEEF);

    // Write pass-through on port 2.
    set_port(2, 25'h0000200, 32'h12345678, 4'b0011);
    expect_txn(2, 32'hCAFEF00D, 5, 1'b1);
    want[2] += 1;
    drain();

    // Port 0 keeps requesting while port 1 waits: 0, 1, 0.
    set_port(0, 25'h0000400, 32'h0, 4'b0000);
    set_port(1, 25'h0000500, 32'h0, 4'b0000);
    expect_txn(0, 32'h0000_00A0, 6, 1'b1);
    expect_txn(1, 32'h0000_00A1, 3, 1'b1);
    expect_txn(0, 32'h0000_00A2, 3, 1'b1);
    want[0] += 2;
    wait_mem_valid();
    want[1] += 1;
    drain();

    // Port 0 and port 1 requesting together after port 0 was last served.
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    expect_txn(0, 32'h0000_00B0, 3, 1'b1);
    expect_txn(0, 32'h0000_00B1, 3, 1'b1);
    expect_txn(0, 32'h0000_00B2, 3, 1'b1);
    expect_txn(1, 32'h0000_00B3, 3, 1'b1);
`else
    expect_txn(1, 32'h0000_00B0, 3, 1'b1);
    expect_txn(0, 32'h0000_00B1, 3, 1'b1);
    expect_txn(0, 32'h0000_00B2, 3, 1'b1);
    expect_txn(0, 32'h0000_00B3, 3, 1'b1);
`endif
    want[0] += 3;
    want[1] += 1;
    drain();

    // Reset while port 0 is being served, then port 1 alone.
    set_port(0, 25'h0000600, 32'h77777777, 4'b1111);
    expect_txn(0, 32'h0, 40, 1'b0);
    want[0] += 1;
    wait_mem_valid();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset   = 1'b1;
    want[0] = served[0];
    @(posedge clk);
    #2;
    check("mid_rst_mem_valid", mem_valid, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_req_dout", req_dout, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_mem_din", mem_din, 0);
    check("mid_rst_mem_wmask", mem_wmask, 0);
    reset = 1'b0;
    set_port(1, 25'h0000700, 32'h0, 4'b0000);
    expect_txn(1, 32'h0000_00C1, 4, 1'b1);
    want[1] += 1;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
